fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_next_pc_calc.sv | 33 +++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// decoder opcode constants and the default reset PC.
package fetch_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned STATE_W  = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
  localparam logic [STATE_W-1:0] ST_VALID = 2'd2;

  localparam logic [OPC_W-1:0] OP_R   = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J   = 6'b000010;
  localparam logic [OPC_W-1:0] OP_JAL = 6'b000011;
  localparam logic [OPC_W-1:0] OP_BEQ = 6'b000100;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or PC+4.
// Jump outranks branch; all arithmetic wraps modulo 2^32.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] NextPC
);

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_off;
  logic [5:0]  unused_opcode;

  assign unused_opcode = Instr[31:26];
  assign pc4           = PC + 32'd4;
  assign jump_target   = {pc4[31:28], Instr[25:0], 2'b00};
  assign branch_off    = {{14{Instr[15]}}, Instr[15:0], 2'b00};

  always_comb begin
    NextPC = pc4;
    if (Jump) begin
      NextPC = jump_target;
    end else if (Branch && Zero) begin
      NextPC = pc4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at PC, holds it for decode until
// downstream accepts it, then advances PC and counts the retired instruction.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic        InstrValid,
  output logic [31:0] PC,
  input  logic        Stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] InstrCount
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        count_q, count_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [31:0]        next_pc;

  next_pc_calc u_next_pc_calc (
    .PC     (pc_q),
    .Instr  (instr_q),
    .Jump   (Jump),
    .Branch (Branch),
    .Zero   (Zero),
    .NextPC (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      count_q <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  // Request/valid flags are registered copies of the decoded next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (!Stall) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d   = (state_d == ST_FETCH);
    valid_d = (state_d == ST_VALID);
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign Opcode     = instr_q[31:26];
  assign InstrValid = valid_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a behavioural reference model and
// directed literal checks on the next-PC rules and reset behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic        InstrValid;
  logic [31:0] PC;
  logic        Stall, Jump, Branch, Zero;
  logic [31:0] InstrCount;

  logic [31:0] t_pc, t_instr, t_next;
  logic        t_jump, t_branch, t_zero;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instr(Instr),
    .Opcode(Opcode), .InstrValid(InstrValid), .PC(PC), .Stall(Stall),
    .Jump(Jump), .Branch(Branch), .Zero(Zero), .InstrCount(InstrCount)
  );

  next_pc_calc u_npc (
    .PC(t_pc), .Instr(t_instr), .Jump(t_jump), .Branch(t_branch),
    .Zero(t_zero), .NextPC(t_next)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit is doing, and the architectural PC.
  typedef enum int {M_IDLE, M_WAIT_MEM, M_HOLD} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_pc, m_instr, m_cnt;
  bit          m_ok = 1'b0;

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b && z) begin
      off = int'(ins & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = M_IDLE;
      m_pc    = RST_PC;
      m_instr = 32'd0;
      m_cnt   = 32'd0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      case (m_phase)
        M_IDLE: m_phase = M_WAIT_MEM;
        M_WAIT_MEM: if (imem_ready) begin
          m_instr = imem_rdata;
          m_phase = M_HOLD;
        end
        M_HOLD: if (!Stall) begin
          m_pc    = model_next(m_pc, m_instr, Jump, Branch, Zero);
          m_cnt   = m_cnt + 32'd1;
          m_phase = M_WAIT_MEM;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Single compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("imem_req",   32'(imem_req),   32'(m_phase == M_WAIT_MEM));
      chk("InstrValid", 32'(InstrValid), 32'(m_phase == M_HOLD));
      chk("imem_addr",  imem_addr, m_pc);
      chk("PC",         PC,        m_pc);
      chk("Instr",      Instr,     m_instr);
      chk("Opcode",     32'(Opcode), m_instr >> 26);
      chk("InstrCount", InstrCount, m_cnt);
    end
  end

  task automatic npc_case(input string name, input logic [31:0] pc, input logic [31:0] ins,
                          input logic j, input logic b, input logic z, input logic [31:0] exp);
    t_pc = pc; t_instr = ins; t_jump = j; t_branch = b; t_zero = z;
    #1;
    chk(name, t_next, exp);
    chk({name, "_model"}, model_next(pc, ins, j, b, z), exp);
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    Stall = 1'b0; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    idle_inputs();

    // Next-PC rules, including jump priority and modulo-2^32 wrap.
    npc_case("npc_jump",      32'h0000_0010, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    npc_case("npc_beq_taken", 32'h0000_0020, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_001C);
    npc_case("npc_beq_not",   32'h0000_0020, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0024);
    npc_case("npc_wrap_seq",  32'hFFFF_FFFC, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
    npc_case("npc_wrap_neg",  32'h0000_0000, 32'h1000_FFFC, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF4);
    npc_case("npc_jump_hi",   32'hFFFF_FFFC, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_addr",  imem_addr, RST_PC);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_count", InstrCount, 32'd0);
    reset = 1'b0;

    // First fetch: one-cycle memory, no stall.
    @(negedge clk);
    chk("f1_req",  32'(imem_req), 32'd1);
    chk("f1_addr", imem_addr, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    @(negedge clk);
    chk("f1_valid", 32'(InstrValid), 32'd1);
    chk("f1_instr", Instr, 32'h2008_0005);
    imem_ready = 1'b0;
    @(negedge clk);
    chk("f1_pc",    PC, 32'd4);
    chk("f1_count", InstrCount, 32'd1);

    // Slow memory: five wait cycles, latched on the sixth.
    repeat (5) begin
      chk("slow_req", 32'(imem_req), 32'd1);
      chk("slow_addr", imem_addr, 32'd4);
      @(negedge clk);
    end
    chk("slow_still_wait", 32'(InstrValid), 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h1000_FFFE;
    @(negedge clk);
    chk("slow_latched", 32'(InstrValid), 32'd1);
    imem_ready = 1'b0;

    // Held three cycles under Stall with branch inputs that must be ignored.
    Stall = 1'b1; Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall_pc",    PC, 32'd4);
    chk("stall_count", InstrCount, 32'd1);
    chk("stall_instr", Instr, 32'h1000_FFFE);
    Stall = 1'b0; Jump = 1'b0;
    @(negedge clk);
    chk("stall_retire_pc", PC, 32'h0000_0000);
    chk("stall_retire_cnt", InstrCount, 32'd2);
    idle_inputs();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      imem_ready = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 3))
        0: imem_rdata = {6'b000010, 26'($urandom)};
        1: imem_rdata = {6'b000100, 10'($urandom), 16'($urandom)};
        default: imem_rdata = $urandom;
      endcase
      Stall  = ($urandom_range(0, 9) < 3);
      Jump   = 1'($urandom);
      Branch = 1'($urandom);
      Zero   = 1'($urandom);
      reset  = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0;

    // Reset while a memory response arrives on the same edge.
    budget = 0;
    idle_inputs();
    while (m_phase != M_WAIT_MEM && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL reach_fetch: got timeout expected fetch state");
    end
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0;
    chk("rstf_instr", Instr, 32'd0);
    chk("rstf_pc",    PC, RST_PC);
    chk("rstf_count", InstrCount, 32'd0);
    chk("rstf_valid", 32'(InstrValid), 32'd0);
    chk("rstf_req",   32'(imem_req), 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
